result_arbiter: RTL and testbench
=================================

Name: result_arbiter

Overview:
- Shares one gradient-to-pixel result unit among NUM_LANES Sobel gradient lanes.
- Each lane presents a signed (gx, gy) pair using a valid/ready handshake; a round-robin arbiter grants one lane per cycle.
- The shared 2-stage pipeline computes |gx|+|gy| and thresholds it to an 8-bit edge pixel, tagged with the source lane.
- Sits between the per-lane Sobel convolution outputs and the output pixel buffer.

Parameters:
- NUM_LANES, 4, number of requesting gradient lanes (2..8).
- GW, 11, gradient width, two's complement.
- THRESH, 128, magnitude at or above which the pixel saturates to 255 (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_LANES  lane i has a gradient pair pending.
- req_gx  in  NUM_LANES*GW  lane i gx at [i*GW +: GW], signed.
- req_gy  in  NUM_LANES*GW  lane i gy at [i*GW +: GW], signed.
- req_ready  out  NUM_LANES  one-hot grant; lane i's pair is accepted this cycle.
- out_valid  out  1  out_pixel/out_lane hold a result.
- out_ready  in  1  downstream accepts the result this cycle.
- out_pixel  out  8  edge pixel.
- out_lane  out  $clog2(NUM_LANES)  source lane of out_pixel.
- pix_count  out  16  number of completed output transfers.

Behaviour:
- Reset is synchronous: at a clk edge with rst=1, all pipeline valids are cleared and out_valid=0, out_pixel=0, out_lane=0, pix_count=0. The RR pointer is set to 0. Any in-flight data is discarded. rst overrides all other inputs in that cycle.
- Stall rule: advance = !out_valid || out_ready. When advance=0, all pipeline registers hold and req_ready=0.
- Arbitration (combinational from registered pointer):
  - When advance=1, req_ready is one-hot on the first lane j with req_valid[j]=1, searching ptr, ptr+1, … modulo NUM_LANES. All zeros if no lane is valid.
  - A transfer occurs when req_valid[j] && req_ready[j].
  - After a transfer from lane j, ptr <= (j+1) mod NUM_LANES. With no transfer, ptr holds.
  - Lanes must hold req_valid and data until granted. The arbiter never grants a lane whose req_valid=0.
- Stage 1, registered on transfer:
  - ax = |gx|, ay = |gy|, zero-extended to GW+1 bits so that |−1024| = 1024.
  - s1_sum = ax + ay, (GW+2)-bit unsigned, max 2048.
  - s1_lane = j; s1_valid <= transfer (when advance=1).
- Stage 2, registered when advance=1:
  - out_pixel <= (s1_sum >= THRESH) ? 255 : s1_sum[7:0].
  - out_lane <= s1_lane; out_valid <= s1_valid.
- Latency: a pair accepted at edge N is registered at edge N, and out_valid=1 after edge N+1 (2 cycles), assuming no stall.
- Throughput: one pair per cycle with out_ready held high. Back-to-back transfers from different lanes are allowed.
- Output hold: while out_valid && !out_ready, out_pixel and out_lane hold stable and s1 holds. No data is lost or duplicated.
- pix_count increments on each out_valid && out_ready and wraps 0xFFFF -> 0x0000.
- Simultaneous requests: exactly one grant. Under continuous requests from all lanes, each lane is served once per NUM_LANES transfers.
- THRESH boundary: s1_sum == THRESH gives 255; THRESH−1 gives THRESH−1.

Test Plan:
- Reset, then lane 0 presents gx=100, gy=100 with out_ready=1 -> req_ready=0001 in the first cycle; out_valid two cycles later with out_pixel=255, out_lane=0, pix_count=1.
- Lane 2 presents gx=−40, gy=50 -> out_pixel=90. Then gx=−1024, gy=0 -> 255. Then gx=64, gy=−63 (sum 127) -> 127. Then gx=64, gy=−64 (sum 128) -> 255.
- All 4 lanes hold req_valid=1 for 8 cycles with out_ready=1 -> grant order 0,1,2,3,0,1,2,3; out_lane follows the same order; pix_count=8.
- Lane 1 valid, out_ready=0 for 5 cycles after the first out_valid -> req_ready=0 during the stall; out_pixel/out_lane are stable; after release there are no lost or duplicated results, in order.
- Assert rst for one cycle while 2 results are in flight -> the next cycle shows out_valid=0, pix_count=0, ptr=0. The lanes 1 and 3 that are still requesting are then granted lane 1 first.
- Preload pix_count to 0xFFFF via 65535 transfers (or force) and complete one more -> pix_count=0x0000.

Source files
------------

// File: rtl/result_arbiter.sv
// result_arbiter: round-robin arbitration of NUM_LANES Sobel gradient lanes
// into one shared 2-stage |gx|+|gy| threshold pipeline producing edge pixels.
module result_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int GW        = 11,
  parameter int THRESH    = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_LANES-1:0]         req_valid,
  input  logic [NUM_LANES*GW-1:0]      req_gx,
  input  logic [NUM_LANES*GW-1:0]      req_gy,
  output logic [NUM_LANES-1:0]         req_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_pixel,
  output logic [$clog2(NUM_LANES)-1:0] out_lane,
  output logic [15:0]                  pix_count
);

  localparam int LW = $clog2(NUM_LANES);
  localparam int SW = GW + 2;

  logic [LW-1:0]            ptr;
  logic                     advance;
  logic                     transfer;
  logic [2*NUM_LANES-1:0]   dbl_valid;
  logic [2*NUM_LANES-1:0]   dbl_grant;
  logic [NUM_LANES-1:0]     rot_valid;
  logic [NUM_LANES-1:0]     rot_grant;
  logic [NUM_LANES-1:0]     grant;
  logic [LW-1:0]            gnt_lane;
  logic [GW-1:0]            sel_gx;
  logic [GW-1:0]            sel_gy;
  logic [GW:0]              gx_ext;
  logic [GW:0]              gy_ext;
  logic [GW:0]              ax;
  logic [GW:0]              ay;
  logic [SW-1:0]            sum;
  logic                     s1_valid;
  logic [SW-1:0]            s1_sum;
  logic [LW-1:0]            s1_lane;

  // Round-robin grant: rotate requests so ptr sits at bit 0, isolate the
  // lowest set bit, then rotate the one-hot result back into lane order.
  always_comb begin
    advance   = !out_valid || out_ready;
    dbl_valid = {req_valid, req_valid} >> ptr;
    rot_valid = dbl_valid[NUM_LANES-1:0];
    rot_grant = rot_valid & (~rot_valid + NUM_LANES'(1));
    dbl_grant = {rot_grant, rot_grant} << ptr;
    grant     = dbl_grant[2*NUM_LANES-1:NUM_LANES];
    req_ready = advance ? grant : '0;
    transfer  = |req_ready;
  end

  // Encode the granted lane and select its gradient pair.
  always_comb begin
    gnt_lane = '0;
    sel_gx   = '0;
    sel_gy   = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (grant[i]) begin
        gnt_lane = LW'(i);
        sel_gx   = req_gx[i*GW +: GW];
        sel_gy   = req_gy[i*GW +: GW];
      end
    end
  end

  // Magnitudes on GW+1 bits so the most negative gradient stays exact.
  always_comb begin
    gx_ext = {sel_gx[GW-1], sel_gx};
    gy_ext = {sel_gy[GW-1], sel_gy};
    ax     = sel_gx[GW-1] ? (~gx_ext + (GW+1)'(1)) : gx_ext;
    ay     = sel_gy[GW-1] ? (~gy_ext + (GW+1)'(1)) : gy_ext;
    sum    = {1'b0, ax} + {1'b0, ay};
  end

  // Arbiter pointer moves past the lane just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (gnt_lane == LW'(NUM_LANES - 1)) ? '0 : gnt_lane + LW'(1);
    end
  end

  // Stage 1: capture magnitude sum and source lane on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_lane  <= '0;
    end else if (advance) begin
      s1_valid <= transfer;
      if (transfer) begin
        s1_sum  <= sum;
        s1_lane <= gnt_lane;
      end
    end
  end

  // Stage 2: threshold to an 8-bit pixel; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_lane  <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      out_pixel <= (s1_sum >= SW'(THRESH)) ? 8'hFF : s1_sum[7:0];
      out_lane  <= s1_lane;
    end
  end

  // Count completed output transfers, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_count <= '0;
    end else if (out_valid && out_ready) begin
      pix_count <= pix_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_result_arbiter.sv
// Self-checking bench for result_arbiter: directed scenarios plus random
// traffic, checked against a cycle-level reference model of the spec rules.
module tb_result_arbiter;

  localparam int NL     = 4;
  localparam int GW     = 11;
  localparam int THRESH = 128;
  localparam int LW     = $clog2(NL);

  logic              clk;
  logic              rst;
  logic [NL-1:0]     req_valid;
  logic [NL*GW-1:0]  req_gx;
  logic [NL*GW-1:0]  req_gy;
  logic [NL-1:0]     req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_pixel;
  logic [LW-1:0]     out_lane;
  logic [15:0]       pix_count;

  int gx_a [NL];
  int gy_a [NL];
  bit keep [NL];

  // reference model state
  int          mptr;
  bit          m1v, m2v;
  int          m1pix, m1lane, m2pix, m2lane;
  logic [15:0] mcnt;
  int          log_q [$];
  int          ngrant;
  logic [NL-1:0] last_rr;

  int ncmp;
  int nfail;

  result_arbiter #(.NUM_LANES(NL), .GW(GW), .THRESH(THRESH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_gx    (req_gx),
    .req_gy    (req_gy),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_lane  (out_lane),
    .pix_count (pix_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    req_gx = '0;
    req_gy = '0;
    for (int i = 0; i < NL; i++) begin
      req_gx[i*GW +: GW] = GW'(gx_a[i]);
      req_gy[i*GW +: GW] = GW'(gy_a[i]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_pix(input int gx, input int gy);
    int s;
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (s >= THRESH) ? 255 : s;
  endfunction

  function automatic int rnd_grad();
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  // One clock: check DUT against model, advance model, then update lanes.
  task automatic do_cycle(output int gl);
    logic [NL-1:0] eg;
    bit adv;
    bit found;
    bit was_rst;
    int idx;
    #1;
    was_rst = rst;
    adv = !m2v || out_ready;
    eg = '0;
    gl = -1;
    found = 0;
    if (adv) begin
      for (int k = 0; k < NL; k++) begin
        idx = (mptr + k) % NL;
        if (!found && req_valid[idx]) begin
          eg[idx] = 1'b1;
          gl = idx;
          found = 1;
        end
      end
    end
    chk("req_ready", req_ready, eg);
    last_rr = req_ready;
    chk("out_valid", out_valid, m2v);
    if (m2v) begin
      chk("out_pixel", out_pixel, m2pix);
      chk("out_lane", out_lane, m2lane);
    end
    chk("pix_count", pix_count, mcnt);
    if (!was_rst && out_valid && out_ready)
      log_q.push_back(int'(out_lane) * 256 + int'(out_pixel));
    if (was_rst) begin
      m1v = 0; m2v = 0; mcnt = '0; mptr = 0;
    end else begin
      if (m2v && out_ready) mcnt = mcnt + 16'd1;
      if (adv) begin
        m2v = m1v; m2pix = m1pix; m2lane = m1lane;
        m1v = found;
        if (found) begin
          m1pix  = exp_pix(gx_a[gl], gy_a[gl]);
          m1lane = gl;
          mptr   = (gl + 1) % NL;
          ngrant++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (!was_rst && found) begin
      if (keep[gl]) begin
        gx_a[gl] = rnd_grad();
        gy_a[gl] = rnd_grad();
      end else begin
        req_valid[gl] = 1'b0;
      end
    end
  endtask

  task automatic cycles(input int n);
    int g;
    for (int i = 0; i < n; i++) do_cycle(g);
  endtask

  task automatic send_one(input int lane, input int gx, input int gy);
    int g;
    bit done;
    done = 0;
    keep[lane] = 0;
    gx_a[lane] = gx;
    gy_a[lane] = gy;
    req_valid[lane] = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      do_cycle(g);
      if (g == lane) done = 1;
    end
    chk("send_granted", 32'(done), 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
  endtask

  initial begin
    int g;
    int guard;
    logic [7:0]    held_pix;
    logic [LW-1:0] held_lane;
    logic [NL-1:0] order [8];
    ncmp = 0; nfail = 0; ngrant = 0;
    mptr = 0; m1v = 0; m2v = 0; mcnt = '0;
    m1pix = 0; m1lane = 0; m2pix = 0; m2lane = 0;
    req_valid = '0;
    for (int i = 0; i < NL; i++) begin gx_a[i] = 0; gy_a[i] = 0; keep[i] = 0; end
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pixel", 32'(out_pixel), 32'd0);
    chk("rst_out_lane", 32'(out_lane), 32'd0);
    chk("rst_pix_count", 32'(pix_count), 32'd0);
    rst = 1'b0;

    // single pair from lane 0, then THRESH boundaries on lane 2
    log_q.delete();
    send_one(0, 100, 100);
    chk("first_grant", 32'(last_rr), 32'h1);
    cycles(3);
    chk("first_count", 32'(pix_count), 32'd1);
    send_one(2, -40, 50);
    send_one(2, -1024, 0);
    send_one(2, 64, -63);
    send_one(2, 64, -64);
    cycles(3);
    chk("dir_n", 32'(log_q.size()), 32'd5);
    if (log_q.size() == 5) begin
      chk("dir_l0_100_100", 32'(log_q[0]), 32'(0*256 + 255));
      chk("dir_m40_50", 32'(log_q[1]), 32'(2*256 + 90));
      chk("dir_m1024_0", 32'(log_q[2]), 32'(2*256 + 255));
      chk("dir_thresh_m1", 32'(log_q[3]), 32'(2*256 + 127));
      chk("dir_thresh", 32'(log_q[4]), 32'(2*256 + 255));
    end

    // all lanes requesting continuously
    pulse_reset();
    log_q.delete();
    for (int i = 0; i < NL; i++) begin
      keep[i] = 1; gx_a[i] = rnd_grad(); gy_a[i] = rnd_grad(); req_valid[i] = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      do_cycle(g);
      order[i] = last_rr;
    end
    req_valid = '0;
    for (int i = 0; i < NL; i++) keep[i] = 0;
    cycles(3);
    for (int i = 0; i < 8; i++) chk("rr_order", 32'(order[i]), 32'(1 << (i % NL)));
    chk("rr_count", 32'(pix_count), 32'd8);
    chk("rr_log_n", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_q.size(); i++)
      chk("rr_out_lane", 32'(log_q[i] / 256), 32'(i % NL));

    // downstream stall with lane 1 streaming
    log_q.delete();
    ngrant = 0;
    keep[1] = 1; gx_a[1] = rnd_grad(); gy_a[1] = rnd_grad(); req_valid[1] = 1'b1;
    cycles(2);
    #1;
    chk("stall_ov", 32'(out_valid), 32'd1);
    held_pix = out_pixel;
    held_lane = out_lane;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_cycle(g);
      chk("stall_rr", 32'(last_rr), 32'd0);
      #1;
      chk("stall_pix", 32'(out_pixel), 32'(held_pix));
      chk("stall_lane", 32'(out_lane), 32'(held_lane));
    end
    out_ready = 1'b1;
    keep[1] = 0;
    cycles(6);
    chk("stall_no_loss", 32'(log_q.size()), 32'(ngrant));

    // reset with results in flight
    pulse_reset();
    keep[1] = 1; keep[3] = 1;
    gx_a[1] = rnd_grad(); gy_a[1] = rnd_grad(); req_valid[1] = 1'b1;
    gx_a[3] = rnd_grad(); gy_a[3] = rnd_grad(); req_valid[3] = 1'b1;
    cycles(3);
    pulse_reset();
    #1;
    chk("inflight_ov", 32'(out_valid), 32'd0);
    chk("inflight_cnt", 32'(pix_count), 32'd0);
    keep[1] = 0; keep[3] = 0;
    do_cycle(g);
    chk("inflight_first", 32'(last_rr), 32'h2);
    cycles(6);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NL; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 2) == 0)) begin
          gx_a[i] = rnd_grad(); gy_a[i] = rnd_grad(); req_valid[i] = 1'b1;
        end
        keep[i] = ($urandom_range(0, 1) == 1);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      do_cycle(g);
    end
    for (int i = 0; i < NL; i++) keep[i] = 0;
    out_ready = 1'b1;
    cycles(12);
    chk("rand_drained", 32'(req_valid), 32'd0);

    // pix_count wrap
    pulse_reset();
    keep[0] = 1; gx_a[0] = 3; gy_a[0] = -4; req_valid[0] = 1'b1;
    guard = 0;
    while (mcnt != 16'hFFFF && guard < 70000) begin
      do_cycle(g);
      guard++;
    end
    chk("wrap_reach", 32'(mcnt), 32'hFFFF);
    do_cycle(g);
    #1;
    chk("wrap_zero", 32'(pix_count), 32'h0);
    req_valid = '0;
    keep[0] = 0;
    cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
